// File: rtl/spi_pkg.sv
// Shared types for the SPI byte sequencer: FSM states, sticky error codes, data width.
package spi_pkg;

  localparam int unsigned SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StGap,
    StErr
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SPI     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous flush that empties it in one cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q;
  logic [AddrW-1:0] rd_ptr_q;
  logic [AddrW:0]   level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == (AddrW + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flush wins over any same-cycle push so nothing survives it.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds spi_master one byte per transfer from a TX FIFO and collects replies into an RX FIFO,
// with inter-transfer gap, per-byte watchdog and sticky error handling.
module spi_byte_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid_i,
  input  logic [SPI_DATA_W-1:0]       tx_data_i,
  output logic                        tx_ready_o,
  output logic                        rx_valid_o,
  output logic [SPI_DATA_W-1:0]       rx_data_o,
  input  logic                        rx_ready_i,
  output logic                        spi_start_o,
  output logic [SPI_DATA_W-1:0]       spi_data_o,
  input  logic [SPI_DATA_W-1:0]       spi_data_i,
  input  logic                        spi_done_i,
  input  logic                        spi_error_i,
  output logic                        busy_o,
  output logic [1:0]                  err_code_o,
  input  logic                        err_clear_i,
  output logic [$clog2(FIFO_DEPTH):0] tx_level_o
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  seq_state_e            state_q, state_d;
  err_code_e             err_q, err_d;
  logic [SPI_DATA_W-1:0] spi_data_q, spi_data_d;
  logic                  start_q, start_d;
  logic [WdW-1:0]        wd_q, wd_d;
  logic [GapW-1:0]       gap_q, gap_d;

  logic                  tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic [SPI_DATA_W-1:0] tx_head;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [LvlW-1:0]       rx_level;
  logic                  unused_rx_level;
  logic                  in_blank;

  assign tx_ready_o      = !tx_full && (state_q != StErr);
  assign tx_push         = tx_valid_i && tx_ready_o;
  assign rx_valid_o      = !rx_empty;
  assign rx_pop          = rx_valid_o && rx_ready_i;
  assign busy_o          = (state_q != StIdle) || !tx_empty;
  assign err_code_o      = err_q;
  assign spi_start_o     = start_q;
  assign spi_data_o      = spi_data_q;
  assign unused_rx_level = ^rx_level;

  sync_fifo #(
    .WIDTH (SPI_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push),
    .wdata_i (tx_data_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .flush_i (tx_flush),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

  sync_fifo #(
    .WIDTH (SPI_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .wdata_i (spi_data_i),
    .pop_i   (rx_pop),
    .rdata_o (rx_data_o),
    .flush_i (1'b0),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level)
  );

  // First WAIT cycle ignores done/error: spi_master may still show the previous done.
  assign in_blank = (wd_q == '0);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    spi_data_d = spi_data_q;
    start_d    = 1'b0;
    wd_d       = wd_q;
    gap_d      = gap_q;
    tx_pop     = 1'b0;
    tx_flush   = 1'b0;
    rx_push    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Only issue when the reply has guaranteed room in RX.
        if (!tx_empty && !rx_full) begin
          state_d    = StIssue;
          spi_data_d = tx_head;
          start_d    = 1'b1;
        end
      end
      StIssue: begin
        tx_pop  = 1'b1;
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (!in_blank && spi_error_i) begin
          err_d    = ERR_SPI;
          tx_flush = 1'b1;
          state_d  = StErr;
        end else if (!in_blank && spi_done_i) begin
          rx_push = 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
        end else if (wd_q == WdLast) begin
          err_d    = ERR_TIMEOUT;
          tx_flush = 1'b1;
          state_d  = StErr;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StErr: begin
        tx_flush = 1'b1;
        if (err_clear_i) begin
          err_d   = ERR_NONE;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      err_q      <= ERR_NONE;
      spi_data_q <= '0;
      start_q    <= 1'b0;
      wd_q       <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      spi_data_q <= spi_data_d;
      start_q    <= start_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
    end
  end

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Self-checking bench for spi_byte_sequencer with a behavioural spi_master stand-in.
module tb_spi_byte_sequencer;

  localparam int XFER    = 3;   // start-to-done latency of the stand-in spi_master
  localparam int GAP     = 2;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_ready_o;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       rx_ready_i = 1'b0;
  logic       spi_start_o;
  logic [7:0] spi_data_o;
  logic [7:0] spi_data_i = 8'h00;
  logic       spi_done_i = 1'b0;
  logic       spi_error_i = 1'b0;
  logic       busy_o;
  logic [1:0] err_code_o;
  logic       err_clear_i = 1'b0;
  logic [3:0] tx_level_o;

  spi_byte_sequencer #(
    .FIFO_DEPTH     (8),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid_i  (tx_valid_i),
    .tx_data_i   (tx_data_i),
    .tx_ready_o  (tx_ready_o),
    .rx_valid_o  (rx_valid_o),
    .rx_data_o   (rx_data_o),
    .rx_ready_i  (rx_ready_i),
    .spi_start_o (spi_start_o),
    .spi_data_o  (spi_data_o),
    .spi_data_i  (spi_data_i),
    .spi_done_i  (spi_done_i),
    .spi_error_i (spi_error_i),
    .busy_o      (busy_o),
    .err_code_o  (err_code_o),
    .err_clear_i (err_clear_i),
    .tx_level_o  (tx_level_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [7:0] resp_q[$];

  int  n_starts = 0;
  int  last_start = -1;
  bit  chk_gap = 1'b0;
  bit  saw_not_ready = 1'b0;

  int         sl_cnt = 0;
  int         sl_xfers = 0;
  int         sl_err_on = 0;
  bit         sl_hang = 1'b0;
  bit         sl_abort = 1'b0;
  logic [7:0] sl_resp = 8'h00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // spi_master stand-in: done (or error) XFER cycles after start, reply taken from resp_q.
  always begin
    @(posedge clk);
    #1;
    spi_done_i  = 1'b0;
    spi_error_i = 1'b0;
    if (sl_abort) begin
      sl_cnt   = 0;
      sl_abort = 1'b0;
    end
    if (sl_cnt > 0) begin
      sl_cnt--;
      if (sl_cnt == 0) begin
        if (sl_xfers == sl_err_on) begin
          spi_error_i = 1'b1;
        end else begin
          spi_done_i = 1'b1;
          spi_data_i = sl_resp;
        end
      end
    end
    if (spi_start_o) begin
      sl_xfers++;
      if (resp_q.size() > 0) sl_resp = resp_q.pop_front();
      else sl_resp = 8'h00;
      sl_cnt = sl_hang ? 0 : XFER;
    end
  end

  // Scoreboards: issued bytes and popped RX bytes, checked in order.
  always @(negedge clk) begin
    if (!rst && spi_start_o) begin
      n_starts++;
      if (exp_tx.size() == 0) chk("tx_unexpected_start", exp_tx.size(), 1);
      else chk("tx_order", spi_data_o, exp_tx.pop_front());
      if (chk_gap && last_start >= 0) chk("start_spacing", 32'((cyc - last_start) >= XFER + GAP), 1);
      last_start = cyc;
    end
    if (!rst && rx_valid_o && rx_ready_i) begin
      if (exp_rx.size() == 0) chk("rx_unexpected_pop", exp_rx.size(), 1);
      else chk("rx_order", rx_data_o, exp_rx.pop_front());
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic [7:0] r, input bit exp_it);
    int n = 0;
    while (!tx_ready_o && n < 1000) begin
      saw_not_ready = 1'b1;
      tick();
      n++;
    end
    if (!tx_ready_o) begin
      chk("push_stall", tx_ready_o, 1);
      return;
    end
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    exp_tx.push_back(d);
    resp_q.push_back(r);
    if (exp_it) exp_rx.push_back(r);
    tick();
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    while (busy_o && n < limit) begin
      tick();
      n++;
    end
    chk(name, busy_o, 0);
  endtask

  task automatic drain_rx(input string name);
    int n = 0;
    rx_ready_i = 1'b1;
    while (rx_valid_o && n < 200) begin
      tick();
      n++;
    end
    rx_ready_i = 1'b0;
    chk(name, rx_valid_o, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_start"}, spi_start_o, 0);
    chk({tag, "_data"}, spi_data_o, 0);
    chk({tag, "_rx_valid"}, rx_valid_o, 0);
    chk({tag, "_tx_ready"}, tx_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_err"}, err_code_o, 0);
    chk({tag, "_tx_level"}, tx_level_o, 0);
  endtask

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] resp;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   base;
    int   n;
    vecs[0] = '{tx: 8'hA5, resp: 8'h3C, exp_rx: 8'h3C};
    vecs[1] = '{tx: 8'h00, resp: 8'hFF, exp_rx: 8'hFF};
    vecs[2] = '{tx: 8'hFF, resp: 8'h00, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h5A, resp: 8'hC3, exp_rx: 8'hC3};

    rst = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single-byte transactions: latency, data hold, RX timing, busy through gap.
    for (int i = 0; i < 4; i++) begin
      push_byte(vecs[i].tx, vecs[i].resp, 1'b1);       // now cycle N+1
      chk("t1_no_early_start", spi_start_o, 0);
      chk("t1_busy_queued", busy_o, 1);
      tick();                                          // N+2
      chk("t1_start_latency", spi_start_o, 1);
      chk("t1_spi_data", spi_data_o, vecs[i].tx);
      repeat (XFER) tick();                            // done cycle
      chk("t1_data_held", spi_data_o, vecs[i].tx);
      chk("t1_rx_not_yet", rx_valid_o, 0);
      tick();
      chk("t1_rx_valid", rx_valid_o, 1);
      chk("t1_rx_data", rx_data_o, vecs[i].exp_rx);
      rx_ready_i = 1'b1;
      tick();
      rx_ready_i = 1'b0;
      chk("t1_rx_popped", rx_valid_o, 0);
      chk("t1_busy_in_gap", busy_o, 1);
      tick();
      chk("t1_busy_fell", busy_o, 0);
      tick();
    end

    // Burst of three with ordered replies.
    chk_gap    = 1'b1;
    last_start = -1;
    push_byte(8'h11, 8'hAA, 1'b1);
    push_byte(8'h22, 8'h55, 1'b1);
    push_byte(8'h33, 8'hCC, 1'b1);
    chk("t2_level_after_push", tx_level_o, 2);
    wait_idle("t2_idle", 500);
    chk("t2_level_empty", tx_level_o, 0);
    drain_rx("t2_rx_drained");
    chk("t2_all_popped", exp_rx.size(), 0);
    chk_gap = 1'b0;
    tick();

    // RX back-pressure: 8 transfers then stall; TX fills up.
    base          = n_starts;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 12; i++) push_byte(8'(8'h80 + i), 8'(8'hB0 + i), 1'b1);
    repeat (300) tick();
    chk("t3_tx_full_seen", saw_not_ready, 1);
    chk("t3_eight_starts", n_starts - base, 8);
    chk("t3_tx_level", tx_level_o, 4);
    chk("t3_busy_stalled", busy_o, 1);
    rx_ready_i = 1'b1;
    wait_idle("t3_idle", 1000);
    drain_rx("t3_rx_drained");
    chk("t3_twelve_starts", n_starts - base, 12);
    chk("t3_all_popped", exp_rx.size(), 0);
    tick();

    // SPI error on the 2nd of 4 bytes.
    base      = n_starts;
    sl_err_on = sl_xfers + 2;
    push_byte(8'h41, 8'h91, 1'b1);
    push_byte(8'h42, 8'h92, 1'b0);
    push_byte(8'h43, 8'h93, 1'b0);
    push_byte(8'h44, 8'h94, 1'b0);
    n = 0;
    while (err_code_o == 2'd0 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_err_code", err_code_o, 1);
    chk("t4_tx_flushed", tx_level_o, 0);
    chk("t4_tx_ready_low", tx_ready_o, 0);
    chk("t4_busy_in_err", busy_o, 1);
    chk("t4_two_starts", n_starts - base, 2);
    exp_tx.delete();
    resp_q.delete();
    chk("t4_rx_valid", rx_valid_o, 1);
    chk("t4_rx_first", rx_data_o, 8'h91);
    tick();
    chk("t4_err_sticky", err_code_o, 1);
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    chk("t4_err_cleared", err_code_o, 0);
    chk("t4_tx_ready_back", tx_ready_o, 1);
    chk("t4_idle", busy_o, 0);
    drain_rx("t4_no_byte2_in_rx");
    chk("t4_all_popped", exp_rx.size(), 0);
    sl_err_on = 0;
    tick();

    // Watchdog: spi_master never finishes.
    sl_hang = 1'b1;
    push_byte(8'h55, 8'h00, 1'b0);
    tick();
    chk("t5_start", spi_start_o, 1);
    repeat (TIMEOUT) tick();
    chk("t5_no_early_timeout", err_code_o, 0);
    tick();
    chk("t5_timeout_code", err_code_o, 2);
    chk("t5_tx_ready_low", tx_ready_o, 0);
    err_clear_i = 1'b1;
    tick();
    err_clear_i = 1'b0;
    sl_hang     = 1'b0;
    chk("t5_err_cleared", err_code_o, 0);
    chk("t5_idle", busy_o, 0);
    tick();

    // Reset mid-WAIT with 3 bytes queued and 2 replies unread.
    base = n_starts;
    for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i), 8'(8'h70 + i), 1'b0);
    n = 0;
    while ((n_starts - base) < 3 && n < 300) begin
      tick();
      n++;
    end
    chk("t6_in_third_xfer", n_starts - base, 3);
    chk("t6_tx_queued", tx_level_o, 3);
    chk("t6_rx_unread", rx_valid_o, 1);
    rst      = 1'b1;
    sl_abort = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    resp_q.delete();
    tick();
    rst = 1'b0;
    check_reset_vals("t6_after_rst");
    repeat (20) tick();
    chk("t6_no_more_starts", n_starts - base, 3);
    chk("t6_still_idle", busy_o, 0);
    chk("t6_rx_empty", rx_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
